// File: rtl/if_prefetch_pkg.sv
// Shared types for the instruction-fetch prefetch stage: branch bus layout,
// queue entry layout and the alignment helper.
package if_prefetch_pkg;

  localparam int BR_WD  = 33;
  localparam int IFQ_WD = 65;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  function automatic logic is_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with synchronous clear and
// a registered occupancy count. Head data is read combinationally.
module ifq_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: the storage array has no reset; only the pointers and count do,
  // so stale words are never observable and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two DEPTH lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: issues sequential SRAM reads, queues returned
// words for ID, and discards everything on a flush or branch redirect.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [31:0]       new_pc,
  input  logic [BR_WD-1:0]  br_bus,
  input  logic              id_ready,
  output logic              if_to_id_valid,
  output logic [IFQ_WD-1:0] if_to_id_bus,
  output logic              inst_sram_en,
  output logic [3:0]        inst_sram_wen,
  output logic [31:0]       inst_sram_addr,
  output logic [31:0]       inst_sram_wdata,
  input  logic [31:0]       inst_sram_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  br_bus_t           br;
  logic [31:0]       fetch_pc;
  logic [31:0]       inflight_pc;
  logic              inflight;
  logic              halted;
  logic [CW-1:0]     count;
  logic [IFQ_WD-1:0] head;
  ifq_entry_t        push_data;
  logic              push;
  logic              pop;
  logic              redirect;
  logic              misaligned;
  logic [OW-1:0]     occ;
  logic              issue;
  logic              fetch_go;

  assign br = br_bus_t'(br_bus);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    redirect       = flush | br.br_e;
    misaligned     = is_misaligned(fetch_pc);
    if_to_id_valid = count != '0;
    pop            = if_to_id_valid & id_ready;
    // A misaligned pc never coexists with a pending read; it is counted as 0.
    occ            = {1'b0, count} - OW'(pop) + OW'(inflight & ~misaligned);
    issue          = !halted && !redirect && (occ < OW'(DEPTH));
    fetch_go       = issue && !misaligned;
    push           = 1'b0;
    push_data      = '0;
    if (!redirect) begin
      if (inflight) begin
        push      = 1'b1;
        push_data = '{adel: 1'b0, pc: inflight_pc, inst: inst_sram_rdata};
      end else if (issue && misaligned) begin
        push      = 1'b1;
        push_data = '{adel: 1'b1, pc: fetch_pc, inst: 32'h0};
      end
    end
  end

  // Reset holds the request low even though the state would allow an issue.
  assign inst_sram_en    = fetch_go & ~rst;
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign if_to_id_bus    = if_to_id_valid ? head : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      halted      <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= flush ? new_pc : br.br_addr;
      inflight <= 1'b0;
      halted   <= 1'b0;
    end else begin
      inflight <= fetch_go;
      if (fetch_go) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (issue && misaligned) begin
        halted <= 1'b1;
      end
    end
  end

  ifq_fifo #(
    .WIDTH(IFQ_WD),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .clear    (redirect),
    .push_data(push_data),
    .head     (head),
    .count    (count)
  );

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a per-cycle vector table of inputs and
// hand-computed outputs, plus a short mid-cycle reset pulse sequence.
module tb_if_prefetch;

  localparam logic [31:0] A = 32'hbfc0_0000;
  localparam logic [31:0] B = 32'hbfc0_0100;
  localparam logic [31:0] F = 32'hbfc0_0380;
  localparam logic [31:0] M = 32'hbfc0_0102;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic [32:0] br_bus = '0;
  logic        id_ready = 1'b0;
  logic        if_to_id_valid;
  logic [64:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'hdead_beef;

  int n_cmp = 0;
  int n_bad = 0;

  if_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .new_pc         (new_pc),
    .br_bus         (br_bus),
    .id_ready       (id_ready),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return a ^ 32'h1357_9bdf;
  endfunction

  // Instruction SRAM: data one cycle after the request, junk otherwise.
  always @(posedge clk) begin
    inst_sram_rdata <= inst_sram_en ? sram_word(inst_sram_addr) : 32'hdead_beef;
  end

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] new_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        adel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic fl, input logic [31:0] np,
                              input logic be, input logic [31:0] ba, input logic rdy,
                              input logic en, input logic [31:0] ad,
                              input logic vl, input logic [31:0] pc, input logic adel);
    vec_t v;
    v.rst = r; v.flush = fl; v.new_pc = np; v.br_e = be; v.br_addr = ba; v.rdy = rdy;
    v.en = en; v.addr = ad; v.valid = vl; v.pc = pc; v.adel = adel;
    return v;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic en, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc, input logic adel);
    check({tag, ".en"}, 65'(inst_sram_en), 65'(en));
    if (en) check({tag, ".addr"}, 65'(inst_sram_addr), 65'(addr));
    check({tag, ".valid"}, 65'(if_to_id_valid), 65'(valid));
    if (valid) check({tag, ".bus"}, if_to_id_bus, {adel, pc, adel ? 32'h0 : sram_word(pc)});
  endtask

  initial begin
    //                 rst fl new_pc be br_addr rdy  en addr    vl pc     adel
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,      0, 0,     0)); // 0 reset
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, A,      0, 0,     0)); // 1 first fetch
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, A+4,    0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, A+8,    1, A,     0)); // 3 first valid
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, A+12,   1, A,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1, A,     0)); // 5 4 outstanding
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1, A,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, A+16,   1, A,     0)); // 7 ready again
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, A+20,   1, A+4,   0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, A+24,   1, A+8,   0));
    vecs.push_back(mk(0, 0, 0, 1, B, 0,  0, 0,      1, A+12,  0)); // 10 branch
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, B,      0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, B+4,    0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, B+8,    1, B,     0));
    vecs.push_back(mk(0, 1, F, 1, B, 1,  0, 0,      1, B+4,   0)); // 14 flush+branch
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, F,      0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, F+4,    0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, F+8,    1, F,     0));
    vecs.push_back(mk(0, 0, 0, 1, M, 0,  0, 0,      1, F+4,   0)); // 18 misaligned br
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1, M,     1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0,      1, M,     1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0,      0, 0,     0)); // 22 halted
    vecs.push_back(mk(0, 1, F, 0, 0, 1,  0, 0,      0, 0,     0)); // 23 flush resumes
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, F,      0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, F+4,    0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, F+8,    1, F,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, F+12,   1, F+4,   0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, F+16,   1, F+8,   0)); // 28 fill queue
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, F+20,   1, F+8,   0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,      1, F+8,   0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,      0, 0,     0)); // 31 reset mid-stream
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0,      0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, A,      0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, A+4,    0, 0,     0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, A+8,    1, A,     0));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst      = vecs[i].rst;
      flush    = vecs[i].flush;
      new_pc   = vecs[i].new_pc;
      br_bus   = {vecs[i].br_e, vecs[i].br_addr};
      id_ready = vecs[i].rdy;
      #1;
      expect_out($sformatf("v%0d", i), vecs[i].en, vecs[i].addr,
                 vecs[i].valid, vecs[i].pc, vecs[i].adel);
      if (vecs[i].rst) check($sformatf("v%0d.rst_bus", i), if_to_id_bus, 65'h0);
    end
    check("wen", 65'(inst_sram_wen), 65'h0);
    check("wdata", 65'(inst_sram_wdata), 65'h0);

    // Short reset pulse between edges while a read is in flight: the
    // returning word must not be queued once reset releases.
    @(posedge clk);
    #1 rst = 1'b1;
    #1 expect_out("pulse.in", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1 rst = 1'b0;
    #1 expect_out("pulse.rel", 1'b1, A, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2 expect_out("pulse.stale", 1'b1, A+4, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2 expect_out("pulse.first", 1'b1, A+8, 1'b1, A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
